fub_rotm_pipe: RTL and testbench
================================

// Module: fub_rotm_pipe
// PURPOSE
//  Thread-aware rotate/mask/shift functional unit: successor to the rotate path of the fixed-point FUB.
//  Generalised in data width, thread count and pipeline depth; elastic valid/ready on both sides.
//  Per-thread flush for in-flight ops. Sits between operand fetch and the backend result bus.
// PARAMETERS
//  W          32  data width; power of 2, 16..64; SHW = $clog2(W)
//  N_THREADS   2  hardware threads; TW = max(1,$clog2(N_THREADS))
//  STAGES      2  pipeline registers between issue and result, 1..4
// PORTS
//  clk        in   1      clock
//  reset      in   1      asynchronous, active-low reset
//  in_valid   in   1      issue slot holds an op
//  in_ready   out  1      unit accepts op this cycle
//  in_thread  in   TW     issuing thread
//  in_op      in   3      0 ROTM, 1 ROTI (insert), 2 SHL, 3 SHR, 4 SHRA; 5..7 illegal
//  in_imm_sel in   1      1: amount from in_sh_imm; 0: from in_b[SHW:0]
//  in_sh_imm  in   SHW    immediate amount
//  in_mb      in   SHW    mask begin, MSB-0 numbering
//  in_me      in   SHW    mask end, MSB-0 numbering
//  in_a       in   W      source
//  in_b       in   W      register amount source
//  in_q       in   W      insert target (ROTI)
//  in_tag     in   6      destination tag, passed through
//  flush      in   N_THREADS  kill in-flight ops of marked threads
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_thread out  TW     thread of result
//  out_tag    out  6      tag of result
//  out_res    out  W      result
//  out_ca     out  1      carry (SHRA only, else 0)
//  out_cr0    out  4      LT,GT,EQ,SO-slot(0) of out_res; see CONFIGURATION
//  out_illegal out 1      op was 5..7; out_res = 0
// BEHAVIOUR
//  - Reset: all stage valids 0; out_valid=0, out_res=0, out_ca=0, out_cr0=0, out_illegal=0; in_ready=1 after release.
//  - Pipeline: STAGES registers, each with its own valid. Stage advances when downstream empty or advancing.
//    in_ready = !stage0_valid || stage0 advances. Accept on in_valid&&in_ready. Unstalled latency = STAGES cycles.
//  - Stall: out_valid&&!out_ready freezes out_* and back-pressures. Full throughput 1 op/cycle, no bubbles.
//  - Compute in first stage; later stages only carry data. sh = imm_sel ? {1'b0,in_sh_imm} : in_b[SHW:0].
//    mask(mb,me): ones from bit mb to me (MSB-0); if mb>me, wrap (ones outside me+1..mb-1).
//    ROTM: rotl(a,sh[SHW-1:0]) & mask.  ROTI: (rotl & mask) | (q & ~mask).
//    SHL: sh[SHW] ? 0 : a<<sh.  SHR: sh[SHW] ? 0 : a>>sh.
//    SHRA: sh[SHW] ? {W{a[W-1]}} : a>>>sh; ca = a[W-1] & (any 1 shifted out).
//    mb/me ignored for shifts; ca=0 for all non-SHRA ops.
//  - Flush: flush[t] clears valid of every stage holding thread t, same cycle (visible next edge).
//    Incl. held out stage. An op offered on in_valid with flush[in_thread]=1 is not accepted into the pipe.
//    Acceptance of an op with flush[in_thread]=1 is dropped, but in_ready still reflects capacity.
//  - Simultaneous flush and out_ready: flushed result never handshakes.
//    Flushed entries free their slot immediately.
//  - Reset asserted mid-operation: all in-flight ops lost, no output handshake.
// CONFIGURATION
//  FUB_ROTM_RECORD_EN defined: out_cr0 = {res<0 signed, res>0 signed, res==0, 1'b0}.
//    Computed in last stage from registered out_res.
//  FUB_ROTM_RECORD_EN undefined: out_cr0 tied to 4'b0; no compare logic.
// TESTING (W=32, N_THREADS=2, STAGES=2 unless noted)
//  ROTM a=0x12345678 sh=8 mb=0 me=31 -> out_res=0x34567812 two cycles after accept.
//  ROTM a=0xFFFFFFFF sh=0 mb=28 me=3 (wrap) -> out_res=0xF000000F.
//  ROTI a=0x000000AB q=0xFFFFFFFF sh=8 mb=16 me=23 -> out_res=0xFFFFABFF.
//  SHRA a=0x80000001 b=1 -> out_res=0xC0000000, ca=1.
//  SHRA b=0x20 -> out_res=0xFFFFFFFF, ca=1.
//  SHL b=0x20 -> out_res=0.
//  SHR a=0x80000000 b=31 -> out_res=0x00000001, ca=0.
//  Back-pressure: 4 back-to-back ops, out_ready low 3 cycles:
//    results in order, tags intact, none lost/duplicated, in_ready low while full.
//  Flush thread 1 with t0/t1/t0 in flight: only the two t0 results emerge.
//    Same-cycle flush of a held output removes it.
//  With FUB_ROTM_RECORD_EN: result 0x80000000 -> cr0=4'b1000; result 0 -> 4'b0010.
//    Without the macro: cr0=0 always.
//  Async reset asserted mid-stream -> out_valid=0 immediately; in_ready=1 first cycle after release.

Source files
------------

// File: rtl/fub_rotm_pipe.sv
// fub_rotm_pipe: thread-aware rotate/mask/shift unit behind an elastic STAGES-deep pipeline.
// Optional feature macro FUB_ROTM_RECORD_EN adds the CR0 compare on the registered result.
module fub_rotm_pipe #(
    parameter int W         = 32,
    parameter int N_THREADS = 2,
    parameter int STAGES    = 2,
    localparam int SHW      = $clog2(W),
    localparam int TW       = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [TW-1:0]        in_thread,
    input  logic [2:0]           in_op,
    input  logic                 in_imm_sel,
    input  logic [SHW-1:0]       in_sh_imm,
    input  logic [SHW-1:0]       in_mb,
    input  logic [SHW-1:0]       in_me,
    input  logic [W-1:0]         in_a,
    input  logic [W-1:0]         in_b,
    input  logic [W-1:0]         in_q,
    input  logic [5:0]           in_tag,
    input  logic [N_THREADS-1:0] flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TW-1:0]        out_thread,
    output logic [5:0]           out_tag,
    output logic [W-1:0]         out_res,
    output logic                 out_ca,
    output logic [3:0]           out_cr0,
    output logic                 out_illegal
);

    typedef enum logic [2:0] {
        OP_ROTM = 3'd0,
        OP_ROTI = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_SHRA = 3'd4
    } op_e;

    typedef struct packed {
        logic [TW-1:0] thr;
        logic [5:0]    tag;
        logic [W-1:0]  res;
        logic          ca;
        logic          ill;
    } ent_t;

    localparam logic [W-1:0] ONES = '1;

    logic [SHW:0]          sh;
    logic [SHW-1:0]        amt;
    logic [2*W-1:0]        dbl;
    logic [W-1:0]          rot, m_lo, m_hi, mask;
    logic signed [W-1:0]   sra;
    ent_t                  c_ent;
    logic                  unused_bits;

    assign unused_bits = ^{in_b[W-1:SHW+1], dbl[W-1:0]};

    // Compute stage: everything is resolved before the first register.
    always_comb begin
        sh    = in_imm_sel ? {1'b0, in_sh_imm} : in_b[SHW:0];
        amt   = sh[SHW-1:0];
        dbl   = {in_a, in_a} << amt;
        rot   = dbl[2*W-1:W];
        m_lo  = ONES >> in_mb;
        m_hi  = ONES >> in_me >> 1;
        mask  = (in_mb <= in_me) ? (m_lo & ~m_hi) : (m_lo | ~m_hi);
        sra   = $signed(in_a) >>> amt;
        c_ent = '0;
        c_ent.thr = in_thread;
        c_ent.tag = in_tag;
        case (op_e'(in_op))
            OP_ROTM: c_ent.res = rot & mask;
            OP_ROTI: c_ent.res = (rot & mask) | (in_q & ~mask);
            OP_SHL:  c_ent.res = sh[SHW] ? '0 : (in_a << amt);
            OP_SHR:  c_ent.res = sh[SHW] ? '0 : (in_a >> amt);
            OP_SHRA: begin
                c_ent.res = sh[SHW] ? {W{in_a[W-1]}} : sra;
                c_ent.ca  = in_a[W-1] & (sh[SHW] ? (|in_a) : (|(in_a & ~(ONES << amt))));
            end
            default: c_ent.ill = 1'b1;
        endcase
    end

    logic [STAGES-1:0] vld_q, eff_v, adv, load;
    ent_t              ent_q [STAGES];
    ent_t              ent_d [STAGES];
    logic              room, accept;

    always_comb begin
        for (int unsigned i = 0; i < STAGES; i++) begin
            eff_v[i] = vld_q[i] & ~flush[ent_q[i].thr];
        end
    end

    // A stage moves when any slot ahead of it is empty (flushed slots count as empty) or the output drains.
    always_comb begin
        room = out_ready;
        adv  = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            adv[STAGES-1-k] = eff_v[STAGES-1-k] & room;
            room            = room | ~eff_v[STAGES-1-k];
        end
        in_ready = ~eff_v[0] | adv[0];
        accept   = in_valid & in_ready & ~flush[in_thread];
        load     = '0;
        load[0]  = accept;
        ent_d[0] = c_ent;
        for (int unsigned i = 1; i < STAGES; i++) begin
            load[i]  = adv[i-1];
            ent_d[i] = ent_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                vld_q[i] <= load[i] | (eff_v[i] & ~adv[i]);
                if (load[i]) begin
                    ent_q[i] <= ent_d[i];
                end
            end
        end
    end

    assign out_valid   = eff_v[STAGES-1];
    assign out_thread  = ent_q[STAGES-1].thr;
    assign out_tag     = ent_q[STAGES-1].tag;
    assign out_res     = ent_q[STAGES-1].res;
    assign out_ca      = ent_q[STAGES-1].ca;
    assign out_illegal = ent_q[STAGES-1].ill;

`ifdef FUB_ROTM_RECORD_EN
    always_comb begin
        out_cr0 = '0;
        if (vld_q[STAGES-1]) begin
            out_cr0 = {out_res[W-1], ~out_res[W-1] & (|out_res), ~(|out_res), 1'b0};
        end
    end
`else
    assign out_cr0 = 4'b0;
`endif

endmodule

// File: tb/tb_fub_rotm_pipe.sv
// Self-checking bench for fub_rotm_pipe: directed vector table, pipeline corner sequences,
// and a randomized run against an in-order queue reference model.
module tb_fub_rotm_pipe;
    localparam int W = 32, N_THREADS = 2, STAGES = 2, SHW = 5, TW = 1;

    logic clk = 1'b0;
    logic reset;
    logic in_valid, in_ready, in_imm_sel;
    logic [TW-1:0] in_thread;
    logic [2:0] in_op;
    logic [SHW-1:0] in_sh_imm, in_mb, in_me;
    logic [W-1:0] in_a, in_b, in_q;
    logic [5:0] in_tag;
    logic [N_THREADS-1:0] flush;
    logic out_valid, out_ready;
    logic [TW-1:0] out_thread;
    logic [5:0] out_tag;
    logic [W-1:0] out_res;
    logic out_ca, out_illegal;
    logic [3:0] out_cr0;

    fub_rotm_pipe #(.W(W), .N_THREADS(N_THREADS), .STAGES(STAGES)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_thread(in_thread), .in_op(in_op),
        .in_imm_sel(in_imm_sel), .in_sh_imm(in_sh_imm), .in_mb(in_mb), .in_me(in_me),
        .in_a(in_a), .in_b(in_b), .in_q(in_q), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_thread(out_thread),
        .out_tag(out_tag), .out_res(out_res), .out_ca(out_ca), .out_cr0(out_cr0),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op; logic imm; logic [4:0] shi, mb, me; logic [31:0] a, b, q;
    } op_t;
    typedef struct {
        op_t i; logic [31:0] res; logic ca; logic ill;
    } vec_t;
    typedef struct {
        logic thr; logic [5:0] tag; logic [31:0] res; logic ca; logic ill;
    } exp_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] cr0_of(input logic [31:0] r);
`ifdef FUB_ROTM_RECORD_EN
        return {$signed(r) < 0, $signed(r) > 0, r == 32'd0, 1'b0};
`else
        return 4'b0;
`endif
    endfunction

    // Reference: bitwise definitions of rotate, MSB-0 mask and shifts, no shared structure with the RTL.
    function automatic exp_t model(input op_t o, input logic thr, input logic [5:0] tag);
        exp_t e;
        int s, mb, me;
        logic [31:0] r, m;
        s  = o.imm ? int'(o.shi) : int'(o.b[5:0]);
        mb = int'(o.mb);
        me = int'(o.me);
        for (int i = 0; i < 32; i++) r[(i + s) % 32] = o.a[i];
        for (int p = 0; p < 32; p++)
            m[31-p] = (mb <= me) ? (p >= mb && p <= me) : (p >= mb || p <= me);
        e.thr = thr; e.tag = tag; e.res = '0; e.ca = 1'b0; e.ill = 1'b0;
        case (o.op)
            3'd0: e.res = r & m;
            3'd1: e.res = (r & m) | (o.q & ~m);
            3'd2: for (int i = 0; i < 32; i++) e.res[i] = (i >= s) ? o.a[i-s] : 1'b0;
            3'd3: for (int i = 0; i < 32; i++) e.res[i] = (i + s < 32) ? o.a[i+s] : 1'b0;
            3'd4: begin
                for (int i = 0; i < 32; i++) e.res[i] = (i + s < 32) ? o.a[i+s] : o.a[31];
                for (int j = 0; j < 32 && j < s; j++) if (o.a[j]) e.ca = o.a[31];
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check_out(input string name, input exp_t e);
        check(name, {out_thread, out_tag, out_illegal, out_ca, out_cr0, out_res},
                    {e.thr, e.tag, e.ill, e.ca, cr0_of(e.res), e.res});
    endtask

    task automatic drive(input op_t o, input logic thr, input logic [5:0] tag);
        in_op = o.op; in_imm_sel = o.imm; in_sh_imm = o.shi; in_mb = o.mb; in_me = o.me;
        in_a = o.a; in_b = o.b; in_q = o.q; in_thread = thr; in_tag = tag;
    endtask

    // Offer an op and hold it until the edge that takes it (bounded).
    task automatic issue(input op_t o, input logic thr, input logic [5:0] tag);
        @(negedge clk);
        drive(o, thr, tag);
        in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (in_ready) break;
            @(negedge clk);
        end
        check("issue_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    vec_t vt [13];
    exp_t bq [4];
    exp_t sq [$];
    exp_t kq [$];
    exp_t e;
    op_t  ro;
    int   lat, seen, held, tt;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{'{3'd0, 1'b1, 5'd8,  5'd0,  5'd31, 32'h12345678, 32'h0,  32'h0},        32'h34567812, 1'b0, 1'b0};
        vt[1]  = '{'{3'd0, 1'b1, 5'd0,  5'd28, 5'd3,  32'hFFFFFFFF, 32'h0,  32'h0},        32'hF000000F, 1'b0, 1'b0};
        vt[2]  = '{'{3'd1, 1'b1, 5'd8,  5'd16, 5'd23, 32'h000000AB, 32'h0,  32'hFFFFFFFF}, 32'hFFFFABFF, 1'b0, 1'b0};
        vt[3]  = '{'{3'd4, 1'b0, 5'd0,  5'd0,  5'd0,  32'h80000001, 32'h1,  32'h0},        32'hC0000000, 1'b1, 1'b0};
        vt[4]  = '{'{3'd4, 1'b0, 5'd0,  5'd0,  5'd0,  32'h80000000, 32'h20, 32'h0},        32'hFFFFFFFF, 1'b1, 1'b0};
        vt[5]  = '{'{3'd2, 1'b0, 5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 32'h20, 32'h0},        32'h00000000, 1'b0, 1'b0};
        vt[6]  = '{'{3'd3, 1'b0, 5'd0,  5'd0,  5'd0,  32'h80000000, 32'd31, 32'h0},        32'h00000001, 1'b0, 1'b0};
        vt[7]  = '{'{3'd5, 1'b0, 5'd0,  5'd0,  5'd31, 32'hFFFFFFFF, 32'h1,  32'h0},        32'h00000000, 1'b0, 1'b1};
        vt[8]  = '{'{3'd4, 1'b0, 5'd0,  5'd0,  5'd0,  32'h7FFFFFFF, 32'h4,  32'h0},        32'h07FFFFFF, 1'b0, 1'b0};
        vt[9]  = '{'{3'd0, 1'b1, 5'd31, 5'd0,  5'd31, 32'h00000001, 32'h0,  32'h0},        32'h80000000, 1'b0, 1'b0};
        vt[10] = '{'{3'd2, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000001, 32'd31, 32'h0},        32'h80000000, 1'b0, 1'b0};
        vt[11] = '{'{3'd0, 1'b1, 5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,  32'h0},        32'h80000000, 1'b0, 1'b0};
        vt[12] = '{'{3'd2, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000001, 32'h41, 32'h0},        32'h00000002, 1'b0, 1'b0};

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = '0;
        drive(vt[0].i, 1'b0, 6'd0);
        repeat (3) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_fields", {out_res, out_ca, out_cr0, out_illegal}, 0);
        reset = 1'b1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);

        // Directed table, one op at a time, latency measured from the accepting edge.
        for (int v = 0; v < 13; v++) begin
            issue(vt[v].i, 1'b0, 6'(v));
            lat = 0;
            do begin
                @(negedge clk); #1; lat++;
            end while (!out_valid && lat < 10);
            check($sformatf("vec%0d_latency", v), lat, STAGES);
            check_out($sformatf("vec%0d_out", v), '{1'b0, 6'(v), vt[v].res, vt[v].ca, vt[v].ill});
        end
        @(negedge clk);

        // Back-pressure: four back-to-back ops, consumer stalls three cycles once a result is held.
        for (int k = 0; k < 4; k++) bq[k] = model(vt[k].i, 1'b0, 6'(20 + k));
        fork
            begin
                for (int k = 0; k < 4; k++) issue(vt[k].i, 1'b0, 6'(20 + k));
            end
            begin
                seen = 0; held = 0; tt = 0;
                out_ready = 1'b0;
                while (seen < 4 && tt < 40) begin
                    @(negedge clk);
                    if (held >= 3) out_ready = 1'b1;
                    #2;
                    tt++;
                    if (out_valid && !out_ready) begin
                        held++;
                        check("bp_in_ready_full", in_ready, 0);
                        check_out("bp_held", bq[0]);
                    end
                    if (out_valid && out_ready) begin
                        check_out($sformatf("bp_out%0d", seen), bq[seen]);
                        seen++;
                    end
                end
                check("bp_count", seen, 4);
            end
        join
        @(negedge clk); #2;
        check("bp_drained", out_valid, 0);

        // Flush thread 1 with t0/t1/t0 in flight; a t1 op offered during the flush is dropped.
        out_ready = 1'b1;
        seen = 0;
        fork
            begin
                issue(vt[0].i, 1'b0, 6'd30);
                issue(vt[1].i, 1'b1, 6'd31);
                flush = 2'b10;
                issue(vt[2].i, 1'b0, 6'd32);
                issue(vt[3].i, 1'b1, 6'd33);
                flush = 2'b00;
            end
            begin
                for (int c = 0; c < 14; c++) begin
                    @(negedge clk); #2;
                    if (out_valid) begin
                        if (seen == 0) check_out("flush_first", model(vt[0].i, 1'b0, 6'd30));
                        else if (seen == 1) check_out("flush_second", model(vt[2].i, 1'b0, 6'd32));
                        else check("flush_extra_tag", out_tag, 6'h3f);
                        seen++;
                    end
                end
            end
        join
        check("flush_count", seen, 2);

        // Flush of a held output in the same cycle the consumer becomes ready.
        out_ready = 1'b0;
        issue(vt[0].i, 1'b1, 6'd40);
        tt = 0;
        do begin @(negedge clk); #2; tt++; end while (!out_valid && tt < 10);
        check("held_valid", out_valid, 1);
        @(negedge clk);
        flush = 2'b10; out_ready = 1'b1;
        @(posedge clk);
        #1 flush = 2'b00;
        check("held_flush_gone", out_valid, 0);
        repeat (3) @(negedge clk);
        check("held_flush_stays_gone", out_valid, 0);

        // Asynchronous reset in the middle of a stalled stream.
        out_ready = 1'b0;
        issue(vt[1].i, 1'b0, 6'd50);
        issue(vt[2].i, 1'b0, 6'd51);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("mid_reset_out_valid", out_valid, 0);
        check("mid_reset_out_res", out_res, 0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk); #1;
        check("post_reset_in_ready", in_ready, 1);
        check("post_reset_out_valid", out_valid, 0);

        // Randomized stream against the queue model.
        sq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            ro.op  = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            ro.imm = 1'($urandom_range(0, 1));
            ro.shi = 5'($urandom);
            ro.mb  = 5'($urandom);
            ro.me  = 5'($urandom);
            ro.a   = $urandom;
            ro.b   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 70));
            ro.q   = $urandom;
            drive(ro, 1'($urandom_range(0, 1)), 6'($urandom));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)};
            #1;
            if (out_valid && out_ready) begin
                if (sq.size() == 0) begin
                    check("rnd_spurious_out", 1, 0);
                end else begin
                    e = sq.pop_front();
                    check_out("rnd_out", e);
                end
            end
            kq.delete();
            foreach (sq[j]) if (!flush[sq[j].thr]) kq.push_back(sq[j]);
            sq = kq;
            if (in_valid && in_ready && !flush[in_thread]) sq.push_back(model(ro, in_thread, in_tag));
        end
        @(negedge clk);
        in_valid = 1'b0; flush = '0; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (out_valid) begin
                if (sq.size() == 0) check("rnd_drain_spurious", 1, 0);
                else begin e = sq.pop_front(); check_out("rnd_drain", e); end
            end
            @(negedge clk);
        end
        check("rnd_all_drained", sq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
